// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion.
// Ports: clk, reset (async high), in_valid/in_ready + plaintext/key in,
// out_valid/out_ready + ciphertext out. Byte 0 = [127:120], column-major.
// Optional macro AES_ENC_ROUND_TAP_EN adds dbg_round[3:0] and dbg_state[127:0].
module aes128_encrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
`ifdef AES_ENC_ROUND_TAP_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state
`endif
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_encrypt_iter: NR must be 10");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]),
            sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Row r of column c comes from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] =
          s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]),
            mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k,
                                              input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       st;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   rnd;
  logic [127:0] next_rk;
  logic [127:0] sr;
  logic [127:0] rnd_full;
  logic [127:0] rnd_last;

  always_comb begin
    next_rk  = key_expand(rk_reg, rcon(rnd));
    sr       = shift_rows(sub_bytes(state_reg));
    rnd_full = mix_columns(sr) ^ next_rk;
    rnd_last = sr ^ next_rk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      ciphertext <= '0;
      state_reg  <= '0;
      rk_reg     <= '0;
      rnd        <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            state_reg <= plaintext ^ key;
            rk_reg    <= key;
            rnd       <= 4'd1;
            in_ready  <= 1'b0;
            st        <= RUN;
          end
        end
        RUN: begin
          rk_reg <= next_rk;
          rnd    <= rnd + 4'd1;
          if (rnd == 4'(NR)) begin
            state_reg  <= rnd_last;
            ciphertext <= rnd_last;
            out_valid  <= 1'b1;
            st         <= DONE;
          end else begin
            state_reg <= rnd_full;
          end
        end
        DONE: begin
          // in_ready rises only after the handshake, so a block waiting
          // on in_valid is taken one cycle later, in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef AES_ENC_ROUND_TAP_EN
  assign dbg_round = (st == RUN) ? rnd : 4'd0;
  assign dbg_state = state_reg;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Scoreboard bench for aes128_encrypt_iter.
// Known-answer vectors, latency, backpressure, back-to-back and reset.
module tb_aes128_encrypt_iter;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
`ifdef AES_ENC_ROUND_TAP_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_state;
`endif

  aes128_encrypt_iter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
`ifdef AES_ENC_ROUND_TAP_EN
    ,
    .dbg_round  (dbg_round),
    .dbg_state  (dbg_state)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  bit prev_ov = 1'b0;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() > 0)
          chk("latency", 128'(cyc - acc_q.pop_front()), 128'd10);
        else
          chk("unexp_valid", 128'd1, 128'd0);
      end
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        hs_cyc = cyc + 1;
        if (exp_q.size() > 0)
          chk("ct", ciphertext, exp_q.pop_front());
        else
          chk("unexp_out", 128'd1, 128'd0);
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] exp, input bit push,
                      input bit hold);
    int n;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (push) begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
    key       = '0;
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // FIPS-197 C.1
    send(P_C1, K_C1, C_C1, 1'b1, 1'b0);
    drain();

    // FIPS-197 B, with optional round-1 tap
    send(P_B, K_B, C_B, 1'b1, 1'b0);
`ifdef AES_ENC_ROUND_TAP_EN
    @(posedge clk);
    #1;
    chk("dbg_r1", dbg_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("dbg_round", 128'(dbg_round), 128'd2);
`endif
    drain();

    // All-zero vector under backpressure
    out_ready = 1'b0;
    send('0, '0, C_Z, 1'b1, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk("bp_valid", 128'(out_valid), 128'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_ct_stable", ciphertext, C_Z);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ov_fall", 128'(out_valid), 128'd0);
    chk("bp_ready_rise", 128'(in_ready), 128'd1);
    chk("ct_retained", ciphertext, C_Z);
    drain();

    // Back-to-back with in_valid held; B loaded while C.1 runs
    send(P_C1, K_C1, C_C1, 1'b1, 1'b1);
    send(P_B, K_B, C_B, 1'b1, 1'b0);
    chk("b2b_gap", 128'(acc_cyc), 128'(hs_cyc + 1));
    drain();

    // Reset at round 5
    send(P_B, K_B, C_B, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
`ifdef AES_ENC_ROUND_TAP_EN
    chk("dbg_round5", 128'(dbg_round), 128'd5);
`endif
    reset = 1'b1;
    #1;
    chk("mid_rst_ov", 128'(out_valid), 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_ct", ciphertext, 128'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_idle", 128'(out_valid), 128'd0);
    send(P_C1, K_C1, C_C1, 1'b1, 1'b0);
    drain();

    // Input noise during RUN
    send('0, '0, C_Z, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    chk("final_q", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
